// File: rtl/tx_main_source.sv
// Transmit-side source for the main FIFO: buffers host words in a small circular
// queue and pushes them one per clock while the FIFO is not pausing.
module tx_main_source #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              pause,
  output logic              push_main,
  output logic [DATA_W-1:0] data_in,
  output logic [CNT_W-1:0]  sent_vc0,
  output logic [CNT_W-1:0]  sent_vc1,
  output logic              busy,
  output logic [1:0]        state_o
);
  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_nxt;
  logic              wr_en, pop;
  logic [DATA_W-1:0] head;

  // The pop decision here is exactly the value push_main takes at the next edge.
  always_comb begin
    host_ready = (count != FULL) && (state != ST_INIT);
    wr_en      = host_valid && host_ready;
    pop        = (state != ST_INIT) && (count != '0) && !pause && !init;
    count_nxt  = count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
    head       = mem[rd_ptr];
  end

  assign state_o = state;

  // NOTE: queue storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_INIT;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      push_main <= 1'b0;
      data_in   <= '0;
      sent_vc0  <= '0;
      sent_vc1  <= '0;
      busy      <= 1'b0;
    end else if (init || state == ST_INIT) begin
      // Flush: queued words are dropped, data_in keeps its last value.
      state     <= init ? ST_INIT : ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      push_main <= 1'b0;
      sent_vc0  <= '0;
      sent_vc1  <= '0;
      busy      <= 1'b0;
    end else begin
      push_main <= pop;
      count     <= count_nxt;
      busy      <= (count_nxt != '0) || pop;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        data_in <= head;
        if (head[DATA_W-1]) begin
          if (sent_vc1 != '1) sent_vc1 <= sent_vc1 + CNT_W'(1);
        end else begin
          if (sent_vc0 != '1) sent_vc0 <= sent_vc0 + CNT_W'(1);
        end
      end
      unique case (state)
        ST_IDLE: if (wr_en) state <= ST_SEND;
        ST_SEND: begin
          if (pause && count_nxt != '0) state <= ST_HOLD;
          else if (count_nxt == '0)     state <= ST_IDLE;
        end
        ST_HOLD: if (!pause) state <= (count != '0) ? ST_SEND : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
